// File: rtl/aes128_inv_cipher_iter_pkg.sv
// ---------------------------------------------------------------------------
// aes128_inv_cipher_iter_pkg
// Shared definitions for the iterative AES-128 decryption core:
//   - FSM state encoding and the round count NR
//   - Rcon table and state byte/word index helpers
//   - GF(2^8) arithmetic (poly 0x11b), forward S-box and the inverse affine map
//   - forward and inverse single-step key schedule functions
// Byte i of a 128-bit state sits at bits [127-8*i -: 8] (FIPS-197 column-major).
// ---------------------------------------------------------------------------
package aes128_inv_cipher_iter_pkg;

  localparam logic [3:0] NR = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KEXP,
    ST_ROUND,
    ST_DONE
  } state_t;

  function automatic logic [7:0] get_byte(input logic [127:0] s, input int idx);
    return s[127 - 8*idx -: 8];
  endfunction

  function automatic logic [31:0] get_word(input logic [127:0] s, input int idx);
    return s[127 - 32*idx -: 32];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x7   = gf_mul(x6, x);
    x14  = gf_mul(x7, x7);
    x15  = gf_mul(x14, x);
    x30  = gf_mul(x15, x15);
    x31  = gf_mul(x30, x);
    x62  = gf_mul(x31, x31);
    x63  = gf_mul(x62, x);
    x126 = gf_mul(x63, x63);
    x127 = gf_mul(x126, x);
    return gf_mul(x127, x127);
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Undoes the forward affine map; the inverse S-box is gf_inv(inv_affine(s)).
  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox_fwd(w[23:16]), sbox_fwd(w[15:8]), sbox_fwd(w[7:0]), sbox_fwd(w[31:24])};
  endfunction

  // K[r] from K[r-1].
  function automatic logic [127:0] key_fwd(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = get_word(rk, 0) ^ sub_rot_word(get_word(rk, 3)) ^ {rc, 24'h0};
    n1 = get_word(rk, 1) ^ n0;
    n2 = get_word(rk, 2) ^ n1;
    n3 = get_word(rk, 3) ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // K[r-1] from K[r]; rc must be Rcon[r].
  function automatic logic [127:0] key_inv(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = get_word(rk, 3) ^ get_word(rk, 2);
    p2 = get_word(rk, 2) ^ get_word(rk, 1);
    p1 = get_word(rk, 1) ^ get_word(rk, 0);
    p0 = get_word(rk, 0) ^ sub_rot_word(p3) ^ {rc, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

endpackage

// File: rtl/aes128_inv_cipher_iter_if.sv
// ---------------------------------------------------------------------------
// aes128_inv_cipher_iter_if
// Valid/ready bus of the decryption core.
//   in_valid/in_ready : ciphertext + key offer (source -> core)
//   ct, key           : 128-bit ciphertext and cipher key
//   out_valid/out_ready: plaintext delivery (core -> consumer)
//   pt                : 128-bit plaintext
// master = source/consumer side, slave = core side.
// ---------------------------------------------------------------------------
interface aes128_inv_cipher_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ct;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] pt;

  modport master (
    output in_valid, ct, key, out_ready,
    input  in_ready, out_valid, pt
  );

  modport slave (
    input  in_valid, ct, key, out_ready,
    output in_ready, out_valid, pt
  );
endinterface

// File: rtl/aes128_inv_cipher_iter_inv_sbox.sv
// ---------------------------------------------------------------------------
// aes_inv_sbox
// AES inverse S-box: inverse affine map followed by GF(2^8) inversion.
//   i_x : 8-bit input byte
//   o_y : 8-bit substituted byte
// ---------------------------------------------------------------------------
module aes_inv_sbox
  import aes128_inv_cipher_iter_pkg::*;
(
  input  logic [7:0] i_x,
  output logic [7:0] o_y
);
  assign o_y = gf_inv(inv_affine(i_x));
endmodule

// File: rtl/aes128_inv_cipher_iter.sv
// ---------------------------------------------------------------------------
// aes128_inv_cipher_iter
// Iterative AES-128 decryption, one inverse round per clock. Round keys are
// derived on the fly: a forward expansion up to K10 (KEXP), then the inverse
// key schedule steps back one key per round (ROUND). With KEY_CACHE=1 the
// last K10 is kept and a repeated key skips the expansion.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous, active-high reset
//   io_bus : slave side of aes128_inv_cipher_iter_if (in_valid/in_ready,
//            ct, key, out_valid/out_ready, pt)
// ---------------------------------------------------------------------------
module aes128_inv_cipher_iter
  import aes128_inv_cipher_iter_pkg::*;
#(
  parameter int KEY_CACHE = 1
) (
  input logic                       clk,
  input logic                       rst,
  aes128_inv_cipher_iter_if.slave   io_bus
);

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = get_byte(s, 4*((c + 4 - r) % 4) + r);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = get_byte(s, 4*c);
      a1 = get_byte(s, 4*c + 1);
      a2 = get_byte(s, 4*c + 2);
      a3 = get_byte(s, 4*c + 3);
      o[127 - 32*c -: 32] = {
        gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
        gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
        gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
        gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
      };
    end
    return o;
  endfunction

  state_t       r_state;
  logic [3:0]   r_rnd;
  logic [127:0] r_data;
  logic [127:0] r_rk;
  logic [127:0] r_key;
  logic [127:0] r_cache_key;
  logic [127:0] r_cache_k10;
  logic         r_cache_valid;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [127:0] r_pt;

  logic [7:0]   w_rcon;
  logic [127:0] w_fwd_rk;
  logic [127:0] w_inv_rk;
  logic [127:0] w_isr;
  logic [127:0] w_isb;
  logic [127:0] w_ark;
  logic [127:0] w_imc;
  logic         w_hit;

  // Both key steps index Rcon by the current round number.
  assign w_rcon   = rcon(r_rnd);
  assign w_fwd_rk = key_fwd(r_rk, w_rcon);
  assign w_inv_rk = key_inv(r_rk, w_rcon);

  assign w_isr = inv_shift_rows(r_data);

  for (genvar gi = 0; gi < 16; gi++) begin : g_isb
    aes_inv_sbox u_isb (
      .i_x (w_isr[127 - 8*gi -: 8]),
      .o_y (w_isb[127 - 8*gi -: 8])
    );
  end

  // w_inv_rk is K[rnd-1], the key added in this inverse round.
  assign w_ark = w_isb ^ w_inv_rk;
  assign w_imc = inv_mix_columns(w_ark);

  assign w_hit = (KEY_CACHE != 0) && r_cache_valid && (io_bus.key == r_cache_key);

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.pt        = r_pt;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values and the update order inside the block is irrelevant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_rnd         <= '0;
      r_data        <= '0;
      r_rk          <= '0;
      r_key         <= '0;
      // NOTE: the key cache is plain flops and is reset with everything else,
      // so a reset is guaranteed to invalidate it.
      r_cache_key   <= '0;
      r_cache_k10   <= '0;
      r_cache_valid <= 1'b0;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_pt          <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (io_bus.in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            if (w_hit) begin
              r_data  <= io_bus.ct ^ r_cache_k10;
              r_rk    <= r_cache_k10;
              r_rnd   <= NR;
              r_state <= ST_ROUND;
            end else begin
              // r_data parks the ciphertext until K10 is known.
              r_data  <= io_bus.ct;
              r_rk    <= io_bus.key;
              r_key   <= io_bus.key;
              r_rnd   <= 4'd1;
              r_state <= ST_KEXP;
            end
          end
        end

        ST_KEXP: begin
          r_rk <= w_fwd_rk;
          if (r_rnd == NR) begin
            r_cache_k10   <= w_fwd_rk;
            r_cache_key   <= r_key;
            r_cache_valid <= 1'b1;
            r_data        <= r_data ^ w_fwd_rk;
            r_state       <= ST_ROUND;
          end else begin
            r_rnd <= r_rnd + 4'd1;
          end
        end

        ST_ROUND: begin
          r_rk  <= w_inv_rk;
          r_rnd <= r_rnd - 4'd1;
          if (r_rnd == 4'd1) begin
            // Final round has no InvMixColumns.
            r_pt        <= w_ark;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_data <= w_imc;
          end
        end

        ST_DONE: begin
          if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
